// File: rtl/regfile_writeback_ctrl.sv
// Write-side controller for the register file: merges ALU and buffered load results onto
// the single write port and tracks outstanding destinations in a pending scoreboard.
module regfile_writeback_ctrl #(
    parameter int NREGS      = 12,
    parameter int ADDR_W     = 5,
    parameter int DATA_W     = 32,
    parameter int FIFO_DEPTH = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              alu_valid,
    input  logic [ADDR_W-1:0] alu_rd,
    input  logic [DATA_W-1:0] alu_data,
    output logic              alu_ready,
    input  logic              mem_valid,
    input  logic [ADDR_W-1:0] mem_rd,
    input  logic [DATA_W-1:0] mem_data,
    output logic              mem_ready,
    input  logic              issue_valid,
    input  logic [ADDR_W-1:0] issue_rd,
    input  logic [ADDR_W-1:0] a1,
    input  logic [ADDR_W-1:0] a2,
    output logic              busy1,
    output logic              busy2,
    output logic              we,
    output logic [ADDR_W-1:0] data_adr,
    output logic [DATA_W-1:0] data_in,
    output logic              err_addr
);

    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

    logic [ADDR_W-1:0] fifo_rd   [FIFO_DEPTH];
    logic [DATA_W-1:0] fifo_data [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [CNT_W-1:0]  count;
    logic [NREGS-1:0]  pending;

    logic              fifo_empty;
    logic              push;
    logic              pop;
    logic              sel_vld_p0;
    logic [ADDR_W-1:0] sel_rd_p0;
    logic [DATA_W-1:0] sel_data_p0;
    logic              write_ok_p0;
    logic              bad_sel_p0;
    logic              bad_issue;
    logic [NREGS-1:0]  set_mask;
    logic [NREGS-1:0]  clr_mask;
    logic [NREGS-1:0]  pending_nxt;

    function automatic logic addr_ok(input logic [ADDR_W-1:0] a);
        return a < ADDR_W'(NREGS);
    endfunction

    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(FIFO_DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign fifo_empty = (count == '0);
    assign mem_ready  = (count < CNT_W'(FIFO_DEPTH));
    assign alu_ready  = fifo_empty;
    assign push       = mem_valid & mem_ready;

    // Stage p0: pick the write source; a buffered load always beats a new ALU result.
    always_comb begin
        pop         = 1'b0;
        sel_vld_p0  = 1'b0;
        sel_rd_p0   = '0;
        sel_data_p0 = '0;
        if (!fifo_empty) begin
            pop         = 1'b1;
            sel_vld_p0  = 1'b1;
            sel_rd_p0   = fifo_rd[rd_ptr];
            sel_data_p0 = fifo_data[rd_ptr];
        end else if (alu_valid) begin
            sel_vld_p0  = 1'b1;
            sel_rd_p0   = alu_rd;
            sel_data_p0 = alu_data;
        end
    end

    assign write_ok_p0 = sel_vld_p0 & addr_ok(sel_rd_p0);
    assign bad_sel_p0  = sel_vld_p0 & ~addr_ok(sel_rd_p0);
    assign bad_issue   = issue_valid & ~addr_ok(issue_rd);

    // Set is applied after clear so a same-edge reissue keeps the register pending.
    always_comb begin
        set_mask = '0;
        clr_mask = '0;
        for (int i = 0; i < NREGS; i++) begin
            if (issue_valid && issue_rd == ADDR_W'(i)) set_mask[i] = 1'b1;
            if (write_ok_p0 && sel_rd_p0 == ADDR_W'(i)) clr_mask[i] = 1'b1;
        end
        pending_nxt = (pending & ~clr_mask) | set_mask;
    end

    always_comb begin
        busy1 = 1'b0;
        busy2 = 1'b0;
        for (int i = 0; i < NREGS; i++) begin
            if (a1 == ADDR_W'(i)) busy1 = pending[i];
            if (a2 == ADDR_W'(i)) busy2 = pending[i];
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_rd[wr_ptr]   <= mem_rd;
            fifo_data[wr_ptr] <= mem_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= next_ptr(wr_ptr);
            if (pop)  rd_ptr <= next_ptr(rd_ptr);
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Stage p1: registered write port, scoreboard and sticky error.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            we       <= 1'b0;
            data_adr <= '0;
            data_in  <= '0;
            err_addr <= 1'b0;
            pending  <= '0;
        end else begin
            we      <= write_ok_p0;
            pending <= pending_nxt;
            if (write_ok_p0) begin
                data_adr <= sel_rd_p0;
                data_in  <= sel_data_p0;
            end
            if (bad_sel_p0 || bad_issue) err_addr <= 1'b1;
        end
    end

endmodule

// File: tb/tb_regfile_writeback_ctrl.sv
// Randomized and directed bench for regfile_writeback_ctrl with a queue-based reference
// model and a scoreboard monitor on the registered write port.
module tb_regfile_writeback_ctrl;

    localparam int NREGS = 12;
    localparam int FD    = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        alu_valid = 1'b0, mem_valid = 1'b0, issue_valid = 1'b0;
    logic [4:0]  alu_rd = '0, mem_rd = '0, issue_rd = '0, a1 = '0, a2 = '0;
    logic [31:0] alu_data = '0, mem_data = '0;
    logic        alu_ready, mem_ready, busy1, busy2, we, err_addr;
    logic [4:0]  data_adr;
    logic [31:0] data_in;

    regfile_writeback_ctrl dut (
        .clk(clk), .rst(rst),
        .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data), .alu_ready(alu_ready),
        .mem_valid(mem_valid), .mem_rd(mem_rd), .mem_data(mem_data), .mem_ready(mem_ready),
        .issue_valid(issue_valid), .issue_rd(issue_rd),
        .a1(a1), .a2(a2), .busy1(busy1), .busy2(busy2),
        .we(we), .data_adr(data_adr), .data_in(data_in), .err_addr(err_addr)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [4:0]  rd;
        logic [31:0] d;
    } ent_t;

    typedef struct {
        logic        we;
        logic [4:0]  adr;
        logic [31:0] data;
        logic        err;
    } exp_t;

    ent_t mq[$];
    exp_t expq[$];
    bit   pend[32];
    bit   merr;
    bit   mon_en = 1'b0;
    bit   last_alu_acc, last_mem_acc;
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit model_busy(input logic [4:0] a);
        return (int'(a) < NREGS) ? pend[a] : 1'b0;
    endfunction

    task automatic model_clear();
        mq.delete();
        expq.delete();
        for (int i = 0; i < 32; i++) pend[i] = 1'b0;
        merr = 1'b0;
    endtask

    // One clock cycle: drive, check combinational outputs, advance the model to the next edge.
    task automatic step(input logic av, input logic [4:0] ard, input logic [31:0] ad,
                        input logic mv, input logic [4:0] mrd, input logic [31:0] md,
                        input logic iv, input logic [4:0] ird,
                        input logic [4:0] q1, input logic [4:0] q2);
        exp_t e;
        ent_t h;
        bit sel, mrdy, ardy;
        logic [4:0]  srd;
        logic [31:0] sd;
        @(negedge clk);
        alu_valid = av; alu_rd = ard; alu_data = ad;
        mem_valid = mv; mem_rd = mrd; mem_data = md;
        issue_valid = iv; issue_rd = ird; a1 = q1; a2 = q2;
        #1;
        mrdy = (mq.size() < FD);
        ardy = (mq.size() == 0);
        chk("mem_ready", 32'(mem_ready), 32'(mrdy));
        chk("alu_ready", 32'(alu_ready), 32'(ardy));
        chk("busy1", 32'(busy1), 32'(model_busy(q1)));
        chk("busy2", 32'(busy2), 32'(model_busy(q2)));
        sel = 1'b0; srd = '0; sd = '0;
        if (mq.size() > 0) begin
            h = mq.pop_front();
            sel = 1'b1; srd = h.rd; sd = h.d;
        end else if (av) begin
            sel = 1'b1; srd = ard; sd = ad;
        end
        last_alu_acc = av && ardy;
        last_mem_acc = mv && mrdy;
        if (last_mem_acc) begin
            h.rd = mrd; h.d = md;
            mq.push_back(h);
        end
        e.we = 1'b0; e.adr = '0; e.data = '0;
        if (sel) begin
            if (int'(srd) < NREGS) begin
                e.we = 1'b1; e.adr = srd; e.data = sd;
                pend[srd] = 1'b0;
            end else begin
                merr = 1'b1;
            end
        end
        if (iv) begin
            if (int'(ird) < NREGS) pend[ird] = 1'b1;
            else merr = 1'b1;
        end
        e.err = merr;
        expq.push_back(e);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (mon_en && expq.size() > 0) begin
                e = expq.pop_front();
                chk("we", 32'(we), 32'(e.we));
                if (e.we) begin
                    chk("data_adr", 32'(data_adr), 32'(e.adr));
                    chk("data_in", data_in, e.data);
                end
                chk("err_addr", 32'(err_addr), 32'(e.err));
            end
        end
    end

    initial begin : watchdog
        #1000000;
        $display("FAIL timeout: simulation did not complete, errors so far %0d", errors);
        $fatal(1, "timeout");
    end

    initial begin : stim
        logic av, mv, iv;
        logic [4:0]  ard, mrd, ird;
        logic [31:0] ad, md;
        bit hold_a, hold_m;
        model_clear();
        #12;
        chk("rst_we", 32'(we), 32'd0);
        chk("rst_data_adr", 32'(data_adr), 32'd0);
        chk("rst_data_in", data_in, 32'd0);
        chk("rst_err", 32'(err_addr), 32'd0);
        chk("rst_alu_ready", 32'(alu_ready), 32'd1);
        chk("rst_mem_ready", 32'(mem_ready), 32'd1);
        chk("rst_busy1", 32'(busy1), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        mon_en = 1'b1;

        // ALU write with scoreboard tracking of rd=3
        step(0, 0, 0, 0, 0, 0, 1, 5'd3, 5'd3, 5'd0);
        step(1, 5'd3, 32'h11, 0, 0, 0, 0, 0, 5'd3, 5'd3);
        step(0, 0, 0, 0, 0, 0, 0, 0, 5'd3, 5'd3);
        idle(1);

        // Simultaneous ALU and load, then back-to-back loads
        step(1, 5'd5, 32'h55, 1, 5'd1, 32'h101, 0, 0, 5'd1, 5'd5);
        step(1, 5'd5, 32'h55, 1, 5'd2, 32'h202, 0, 0, 5'd2, 5'd5);
        step(1, 5'd5, 32'h55, 1, 5'd4, 32'h404, 0, 0, 5'd4, 5'd5);
        step(1, 5'd5, 32'h55, 0, 0, 0, 0, 0, 5'd4, 5'd5);
        step(1, 5'd5, 32'h55, 0, 0, 0, 0, 0, 5'd4, 5'd5);
        idle(1);

        // Set/clear collision on rd=7
        step(0, 0, 0, 0, 0, 0, 1, 5'd7, 5'd7, 5'd0);
        step(1, 5'd7, 32'h77, 0, 0, 0, 1, 5'd7, 5'd7, 5'd0);
        step(0, 0, 0, 0, 0, 0, 0, 0, 5'd7, 5'd0);
        step(1, 5'd7, 32'h78, 0, 0, 0, 0, 0, 5'd7, 5'd0);
        step(0, 0, 0, 0, 0, 0, 0, 0, 5'd7, 5'd0);

        // Address 0 is an ordinary register
        step(0, 0, 0, 1, 5'd0, 32'hDEAD_BEEF, 0, 0, 5'd0, 5'd0);
        idle(2);

        // Out-of-range ALU destination, then a normal write to the top register
        step(1, 5'd12, 32'hBAD, 0, 0, 0, 0, 0, 5'd12, 5'd11);
        step(1, 5'd11, 32'hB0B, 0, 0, 0, 1, 5'd11, 5'd11, 5'd12);
        idle(2);

        // Randomized traffic obeying the hold-while-stalled rule
        hold_a = 1'b0; hold_m = 1'b0;
        av = 0; ard = 0; ad = 0; mv = 0; mrd = 0; md = 0;
        for (int n = 0; n < 400; n++) begin
            if (!hold_a) begin
                av = ($urandom_range(0, 99) < 55);
                ard = 5'($urandom_range(0, 12));
                ad = $urandom;
            end
            if (!hold_m) begin
                mv = ($urandom_range(0, 99) < 50);
                mrd = 5'($urandom_range(0, 12));
                md = $urandom;
            end
            iv = ($urandom_range(0, 99) < 40);
            ird = 5'($urandom_range(0, 12));
            step(av, ard, ad, mv, mrd, md, iv, ird,
                 5'($urandom_range(0, 13)), 5'($urandom_range(0, 13)));
            hold_a = av && !last_alu_acc;
            hold_m = mv && !last_mem_acc;
        end
        idle(2);

        // Reset in the middle of a cycle with a load buffered and a write in flight
        step(0, 0, 0, 0, 0, 0, 1, 5'd9, 5'd9, 5'd0);
        step(1, 5'd6, 32'h66, 1, 5'd9, 32'h99, 0, 0, 5'd9, 5'd6);
        step(0, 0, 0, 1, 5'd10, 32'hAA, 0, 0, 5'd9, 5'd10);
        @(posedge clk);
        #3;
        mon_en = 1'b0;
        chk("pre_rst_we", 32'(we), 32'd1);
        rst = 1'b1;
        #1;
        chk("async_rst_we", 32'(we), 32'd0);
        chk("async_rst_err", 32'(err_addr), 32'd0);
        alu_valid = 0; mem_valid = 0; issue_valid = 0;
        model_clear();
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        mon_en = 1'b1;
        idle(3);
        step(0, 0, 0, 0, 0, 0, 0, 0, 5'd9, 5'd10);
        step(1, 5'd2, 32'h1234_5678, 0, 0, 0, 0, 0, 5'd2, 5'd0);
        idle(2);
        @(posedge clk);
        #2;
        chk("scoreboard_drained", 32'(expq.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
